// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling on an oversampling tick,
// one-entry holding register with valid/ack handshake and error pulses.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       os_tick,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          scnt_q, scnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   deliver;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    if (os_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            scnt_d  = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (scnt_q == HALF_M1) begin
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              scnt_d    = '0;
              bit_idx_d = 3'd0;
              state_d   = S_DATA;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (scnt_q == FULL_M1) begin
            shift_d[bit_idx_q] = rxs;
            scnt_d             = '0;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_STOP;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (scnt_q == FULL_M1) begin
            scnt_d = '0;
            if (rxs) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A delivery with a same-clk ack replaces the held byte instead of overrunning.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = busy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: os_tick every 4 clks (64 clks per bit),
// frames driven bit by bit, expected values written by hand.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       os_tick = 1'b0;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  int n_cmp = 0;
  int n_err = 0;

  int tick_cnt     = 0;
  int fe_cnt       = 0;
  int ov_cnt       = 0;
  int both_cnt     = 0;
  int long_cnt     = 0;
  int busy_rise    = 0;
  logic fe_prev    = 1'b0;
  logic ov_prev    = 1'b0;
  logic busy_prev  = 1'b0;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .os_tick     (os_tick),
    .rx_in       (rx_in),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Tick for the next rising edge is set on the falling edge.
  always @(negedge clk) begin
    os_tick = (tick_cnt == 3);
    tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
  end

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (frame_err && overrun_err) both_cnt++;
    if ((frame_err && fe_prev) || (overrun_err && ov_prev)) long_cnt++;
    if (rx_busy && !busy_prev) busy_rise++;
    fe_prev   = frame_err;
    ov_prev   = overrun_err;
    busy_prev = rx_busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts right after an os_tick edge; ack_dlv pulses rx_ack in the clk
  // of the stop-bit midpoint tick (612 clks after that reference edge).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack_dlv);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    while (!os_tick) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      rx_in = bits[k];
      for (int j = 0; j < BIT_CLKS; j++) begin
        @(posedge clk);
        #1;
        if (ack_dlv && k == 9) rx_ack = (j == 34);
      end
    end
    $display("frame sent: data=0x%02h stop=%0d ack_in_delivery=%0d", b, stop_bit, ack_dlv);
  endtask

  task automatic do_ack(input string tag);
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
    @(negedge clk);
    check_eq(tag, rx_valid, 1'b0);
    $display("ack: %s", tag);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    @(negedge clk);
    check_eq({tag, "_valid"}, rx_valid, 1'b1);
    check_eq({tag, "_data"}, rx_data, b);
  endtask

  initial begin
    int fe0, ov0, br0;
    rst_n  = 1'b0;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_busy", rx_busy, 1'b0);
    check_eq("rst_errs", {frame_err, overrun_err}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clks(20);

    // Basic frame
    send_frame(8'hA5, 1'b1, 1'b0);
    expect_byte("a5", 8'hA5);
    check_eq("a5_busy_after", rx_busy, 1'b0);
    do_ack("a5_ack");

    // Back-to-back frames, each acked before the next start bit
    begin
      logic [7:0] seq [3];
      seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
      br0 = busy_rise;
      for (int i = 0; i < 3; i++) begin
        send_frame(seq[i], 1'b1, 1'b0);
        expect_byte($sformatf("b2b%0d", i), seq[i]);
        check_eq($sformatf("b2b%0d_busy_gap", i), rx_busy, 1'b0);
        do_ack($sformatf("b2b%0d_ack", i));
      end
      check_eq("b2b_busy_rises", busy_rise - br0, 3);
    end

    // Glitch: line low for 3 ticks only
    wait_clks(10);
    br0 = busy_rise;
    rx_in = 1'b0;
    wait_clks(12);
    rx_in = 1'b1;
    wait_clks(3 * BIT_CLKS);
    @(negedge clk);
    check_eq("glitch_busy_pulse", busy_rise - br0, 1);
    check_eq("glitch_busy_now", rx_busy, 1'b0);
    check_eq("glitch_valid", rx_valid, 1'b0);
    $display("glitch: 12 clks low");

    // Framing error followed by a long break
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_clks(20 * BIT_CLKS);
    @(negedge clk);
    check_eq("fe_count", fe_cnt - fe0, 1);
    check_eq("fe_valid", rx_valid, 1'b0);
    check_eq("fe_busy_in_break", rx_busy, 1'b1);
    rx_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    @(negedge clk);
    check_eq("fe_busy_after_break", rx_busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    expect_byte("after_fe", 8'h81);
    do_ack("after_fe_ack");

    // Overrun: second byte dropped
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    expect_byte("ov_first", 8'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("ov_count", ov_cnt - ov0, 1);
    check_eq("ov_data_kept", rx_data, 8'h11);
    check_eq("ov_valid", rx_valid, 1'b1);
    do_ack("ov_ack");

    // Ack in the delivery clk replaces the held byte
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    expect_byte("swap_first", 8'h11);
    send_frame(8'h22, 1'b1, 1'b1);
    expect_byte("swap", 8'h22);
    check_eq("swap_no_ov", ov_cnt - ov0, 0);

    // Reset during data bit 4 of 0x96 while 0x22 is still held
    @(posedge clk);
    #1;
    while (!os_tick) begin
      @(posedge clk);
      #1;
    end
    rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    begin
      logic [7:0] b;
      b = 8'h96;
      for (int k = 0; k < 4; k++) begin
        rx_in = b[k];
        wait_clks(BIT_CLKS);
      end
      rx_in = b[4];
    end
    wait_clks(BIT_CLKS / 2);
    @(negedge clk);
    check_eq("mid_busy", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", rx_data, 8'h00);
    check_eq("mid_rst_valid", rx_valid, 1'b0);
    check_eq("mid_rst_busy", rx_busy, 1'b0);
    $display("reset asserted during bit 4 of 0x96");
    wait_clks(3);
    rx_in = 1'b1;
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    @(negedge clk);
    check_eq("post_rst_valid", rx_valid, 1'b0);
    send_frame(8'h96, 1'b1, 1'b0);
    expect_byte("post_rst", 8'h96);
    do_ack("post_rst_ack");

    check_eq("err_coincide", both_cnt, 0);
    check_eq("err_width", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
